// File: rtl/alu_pkg.sv
// Shared op codes and FSM state encoding for the chunk-serial ALU.
// Optional flags output is enabled in sliced_alu by defining SLICED_ALU_FLAGS_EN.
package alu_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_XOR = 3'b010;
    localparam logic [2:0] OP_NOR = 3'b011;
    localparam logic [2:0] OP_ADD = 3'b100;
    localparam logic [2:0] OP_SUB = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op_code);
        return (op_code == OP_ADD) || (op_code == OP_SUB);
    endfunction

endpackage

// File: rtl/chunk_alu.sv
// Combinational CHUNK-bit ALU slice; 0 cycles latency, no flow control.
// Reserved op codes produce zero with no carry out.
module chunk_alu
    import alu_pkg::*;
#(
    parameter int CHUNK = 8
) (
    input  logic [2:0]       op,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] r,
    output logic             cout,
    output logic             c_msb_in
);

    logic [CHUNK-1:0] w_b_eff;
    logic [CHUNK:0]   w_sum;

    // SUB is x + ~y + 1: the +1 arrives through cin on the first chunk.
    assign w_b_eff = (op == OP_SUB) ? ~b : b;
    assign w_sum   = {1'b0, a} + {1'b0, w_b_eff} + {{CHUNK{1'b0}}, cin};

    always_comb begin
        r        = '0;
        cout     = 1'b0;
        c_msb_in = 1'b0;
        case (op)
            OP_AND: r = a & b;
            OP_OR:  r = a | b;
            OP_XOR: r = a ^ b;
            OP_NOR: r = ~(a | b);
            OP_ADD, OP_SUB: begin
                r        = w_sum[CHUNK-1:0];
                cout     = w_sum[CHUNK];
                // sum bit = a ^ b ^ carry-in, so the carry into the MSB falls out directly
                c_msb_in = a[CHUNK-1] ^ w_b_eff[CHUNK-1] ^ w_sum[CHUNK-1];
            end
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/sliced_alu.sv
// Chunk-serial ALU: WIDTH/CHUNK cycles from accept to out_valid, one op in flight.
// Backpressure: result held in DONE until out_ready; no accept outside IDLE. Flags via SLICED_ALU_FLAGS_EN.
module sliced_alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CHUNK = 8
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] z
`ifdef SLICED_ALU_FLAGS_EN
    ,
    output logic [2:0]       flags
`endif
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    state_t           r_state;
    logic             r_in_ready;
    logic             r_out_valid;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_x;
    logic [WIDTH-1:0] r_y;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic [WIDTH-1:0] r_z;

    logic [31:0]      w_base;
    logic             w_last;
    logic [CHUNK-1:0] w_a;
    logic [CHUNK-1:0] w_b;
    logic [CHUNK-1:0] w_r;
    logic             w_cout;
    logic             w_cmsb;
    logic [WIDTH-1:0] w_z_next;

    assign w_base = 32'(r_cnt) * CHUNK;
    assign w_last = (r_cnt == CW'(NCHUNK - 1));
    assign w_a    = r_x[w_base +: CHUNK];
    assign w_b    = r_y[w_base +: CHUNK];

    chunk_alu #(.CHUNK(CHUNK)) u_chunk (
        .op       (r_op),
        .a        (w_a),
        .b        (w_b),
        .cin      (r_carry),
        .r        (w_r),
        .cout     (w_cout),
        .c_msb_in (w_cmsb)
    );

    always_comb begin
        w_z_next                   = r_z;
        w_z_next[w_base +: CHUNK]  = w_r;
    end

`ifdef SLICED_ALU_FLAGS_EN
    logic [2:0] r_flags;

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_flags <= '0;
        end else if (r_state == ST_RUN && w_last) begin
            r_flags <= {is_arith(r_op) & (w_cout ^ w_cmsb),
                        is_arith(r_op) & w_cout,
                        (w_z_next == '0)};
        end
    end

    assign flags = r_flags;
`endif

    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_op        <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_cnt       <= '0;
            r_carry     <= 1'b0;
            r_z         <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (in_valid) begin
                        r_op       <= op;
                        r_x        <= x;
                        r_y        <= y;
                        r_cnt      <= '0;
                        r_carry    <= (op == OP_SUB);
                        r_in_ready <= 1'b0;
                        r_state    <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_z     <= w_z_next;
                    r_carry <= w_cout;
                    if (w_last) begin
                        r_out_valid <= 1'b1;
                        r_state     <= ST_DONE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign z         = r_z;

endmodule
